// File: rtl/timer_ctrl.sv
// Memory-mapped prescaled timer with compare interrupt and one-shot/periodic modes.
// Define TIMER_PERIODIC_EN to implement CTRL.periodic; otherwise every expiry is one-shot.
module timer_ctrl #(
    parameter int PRESCALE_MAX = 49,
    parameter int CNT_WIDTH    = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        irq
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [23:0]          PSC_MAX = 24'(PRESCALE_MAX);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_e               state_q, state_d;
    logic [23:0]          psc_q, psc_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic [CNT_WIDTH-1:0] compare_q, compare_d;
    logic                 irq_en_q, irq_en_d;
    logic                 pending_q, pending_d;
    logic                 ready_q, ready_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 periodic;

    logic        accept, wr_ctrl, wr_count, wr_compare, tick;
    logic [31:0] rd_mux;

`ifdef TIMER_PERIODIC_EN
    logic periodic_q, periodic_d;
    assign periodic = periodic_q;
`else
    assign periodic = 1'b0;
`endif

    always_comb begin
        accept     = sel & ~ready_q;
        wr_ctrl    = accept & we & (addr == 2'd0);
        wr_count   = accept & we & (addr == 2'd1);
        wr_compare = accept & we & (addr == 2'd2);
        tick       = (state_q == RUN) && (psc_q == PSC_MAX);

        case (addr)
            2'd0:    rd_mux = {28'd0, pending_q, periodic, irq_en_q, state_q != IDLE};
            2'd1:    rd_mux = 32'(count_q);
            2'd2:    rd_mux = 32'(compare_q);
            default: rd_mux = {psc_q, 6'd0, state_q};
        endcase
    end

    always_comb begin
        state_d   = state_q;
        psc_d     = psc_q;
        count_d   = count_q;
        compare_d = compare_q;
        irq_en_d  = irq_en_q;
        pending_d = pending_q;
`ifdef TIMER_PERIODIC_EN
        periodic_d = periodic_q;
`endif

        if (state_q == RUN)
            psc_d = (psc_q == PSC_MAX) ? '0 : psc_q + 24'd1;

        // The W1C clear is applied first so a same-edge expiry overrides it.
        if (wr_ctrl) begin
            irq_en_d = wdata[1];
`ifdef TIMER_PERIODIC_EN
            periodic_d = wdata[2];
`endif
            if (wdata[3])
                pending_d = 1'b0;
        end

        // A COUNT/COMPARE write on a tick edge takes precedence over the whole tick.
        if (tick && !wr_count && !wr_compare) begin
            if (count_q == compare_q) begin
                pending_d = 1'b1;
                if (periodic)
                    count_d = '0;
                else
                    state_d = DONE;
            end else begin
                count_d = count_q + CNT_ONE;
            end
        end

        if (wr_count)
            count_d = wdata[CNT_WIDTH-1:0];
        if (wr_compare)
            compare_d = wdata[CNT_WIDTH-1:0];

        if (wr_ctrl) begin
            if (wdata[0]) begin
                state_d = RUN;
                psc_d   = '0;
            end else begin
                state_d = IDLE;
            end
        end

        ready_d = accept;
        rdata_d = (accept && !we) ? rd_mux : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            psc_q      <= '0;
            count_q    <= '0;
            compare_q  <= '0;
            irq_en_q   <= 1'b0;
            pending_q  <= 1'b0;
            ready_q    <= 1'b0;
            rdata_q    <= '0;
`ifdef TIMER_PERIODIC_EN
            periodic_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            psc_q      <= psc_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            irq_en_q   <= irq_en_d;
            pending_q  <= pending_d;
            ready_q    <= ready_d;
            rdata_q    <= rdata_d;
`ifdef TIMER_PERIODIC_EN
            periodic_q <= periodic_d;
`endif
        end
    end

    assign rdata = rdata_q;
    assign ready = ready_q;
    assign irq   = pending_q & irq_en_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed and randomized bench for timer_ctrl with PRESCALE_MAX=3; expiry times are
// predicted arithmetically from the programmed COUNT/COMPARE values.
module tb_timer_ctrl;

    localparam int P   = 3;
    localparam int TPT = P + 1;

    logic        clk;
    logic        reset;
    logic        sel;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        irq;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int acc_edge = 0;

    timer_ctrl #(.PRESCALE_MAX(P), .CNT_WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .sel   (sel),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .ready (ready),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the access is accepted on the following posedge.
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        sel = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        acc_edge = cyc;
        sel = 1'b0; we = 1'b0;
        @(negedge clk);
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        sel = 1'b1; we = 1'b0; addr = a;
        @(negedge clk);
        acc_edge = cyc;
        check("read_ready", {31'd0, ready}, 32'd1);
        d = rdata;
        sel = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic wait_irq(input int e0, output int delta);
        delta = -1;
        for (int i = 0; i < 300; i++) begin
            if (irq === 1'b1) begin
                delta = cyc - e0;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        logic [31:0] r;
        int e0, d, x;

        reset = 1'b1; sel = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        @(negedge clk); @(negedge clk);
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Reset while running with a read in flight
        bus_write(2'd2, 32'd100);
        bus_write(2'd0, 32'h3);
        repeat (5) @(negedge clk);
        sel = 1'b1; we = 1'b0; addr = 2'd1;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_ready", {31'd0, ready}, 32'd0);
        check("midrst_rdata", rdata, 32'd0);
        check("midrst_irq", {31'd0, irq}, 32'd0);
        sel = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        bus_read(2'd3, r); check("midrst_status", r, 32'd0);
        bus_read(2'd1, r); check("midrst_count", r, 32'd0);
        bus_read(2'd0, r); check("midrst_ctrl", r, 32'd0);

        // One-shot: COMPARE=4 -> (4+1)*(3+1) = 20 clocks
        bus_write(2'd2, 32'd4);
        bus_write(2'd0, 32'h3);
        e0 = acc_edge;
        wait_irq(e0, d);
        check("oneshot_delay", d, 32'd20);
        bus_read(2'd3, r); check("oneshot_status", r, 32'h2);
        bus_read(2'd1, r); check("oneshot_count", r, 32'd4);
        repeat (40) @(negedge clk);
        bus_read(2'd1, r); check("oneshot_count_hold", r, 32'd4);
        bus_read(2'd0, r); check("oneshot_ctrl", r, 32'hB);

        // sel held with a read: ready toggles every cycle
        sel = 1'b1; we = 1'b0; addr = 2'd0;
        for (int i = 0; i < 6; i++) begin
            if (i != 0) @(negedge clk);
            check("hold_ready", {31'd0, ready}, i % 2);
        end
        sel = 1'b0;
        @(negedge clk); @(negedge clk);

        // Clear on the exact expiry edge: set wins
        bus_write(2'd0, 32'h8);
        bus_write(2'd1, 32'd0);
        bus_write(2'd2, 32'd1);
        bus_write(2'd0, 32'h3);
        x = acc_edge + 2 * TPT;
        wait_until(x - 1);
        bus_write(2'd0, 32'hA);
        check("raceA_irq", {31'd0, irq}, 32'd1);
        bus_read(2'd0, r); check("raceA_ctrl", r, 32'hA);

        // Clear one cycle after expiry: pending drops
        bus_write(2'd0, 32'h8);
        bus_write(2'd1, 32'd0);
        bus_write(2'd0, 32'h3);
        x = acc_edge + 2 * TPT;
        wait_until(x);
        check("raceB_pre_irq", {31'd0, irq}, 32'd1);
        bus_write(2'd0, 32'hA);
        check("raceB_irq", {31'd0, irq}, 32'd0);
        bus_read(2'd0, r); check("raceB_ctrl", r, 32'h2);

        // COUNT write on a tick edge
        bus_write(2'd0, 32'h8);
        bus_write(2'd1, 32'd0);
        bus_write(2'd2, 32'd100);
        bus_write(2'd0, 32'h3);
        e0 = acc_edge;
        wait_until(e0 + 2 * TPT - 1);
        bus_write(2'd1, 32'd10);
        wait_until(e0 + 9);
        bus_read(2'd3, r); check("coll_status", r, 32'h101);
        wait_until(e0 + 11);
        bus_read(2'd1, r); check("coll_count", r, 32'd10);
        wait_until(e0 + 13);
        bus_read(2'd1, r); check("coll_count_next", r, 32'd11);

        // Wrap: 0xFFFFFFFF -> 0 -> 1 -> expiry
        bus_write(2'd0, 32'h8);
        bus_write(2'd2, 32'd1);
        bus_write(2'd1, 32'hFFFF_FFFF);
        bus_write(2'd0, 32'h3);
        e0 = acc_edge;
        wait_until(e0 + 5);
        bus_read(2'd1, r); check("wrap_count0", r, 32'd0);
        wait_until(e0 + 9);
        bus_read(2'd1, r); check("wrap_count1", r, 32'd1);
        wait_irq(e0, d);
        check("wrap_delay", d, 32'd12);
        bus_read(2'd1, r); check("wrap_count_final", r, 32'd1);

`ifdef TIMER_PERIODIC_EN
        bus_write(2'd0, 32'h8);
        bus_write(2'd1, 32'd0);
        bus_write(2'd2, 32'd2);
        bus_write(2'd0, 32'h7);
        e0 = acc_edge;
        bus_read(2'd0, r); check("per_ctrl", r, 32'h7);
        wait_until(e0 + 3);
        bus_read(2'd1, r); check("per_count_a", r, 32'd0);
        wait_until(e0 + 5);
        bus_read(2'd1, r); check("per_count_b", r, 32'd1);
        wait_until(e0 + 9);
        bus_read(2'd1, r); check("per_count_c", r, 32'd2);
        wait_until(e0 + 12);
        check("per_first_irq", {31'd0, irq}, 32'd1);
        for (int k = 0; k < 2; k++) begin
            bus_write(2'd0, 32'hF);
            e0 = acc_edge;
            check("per_clear_irq", {31'd0, irq}, 32'd0);
            bus_read(2'd1, r); check("per_count_wrap", r, 32'd0);
            wait_irq(e0, d);
            check("per_interval", d, 32'd12);
        end
`else
        bus_write(2'd0, 32'h8);
        bus_write(2'd1, 32'd0);
        bus_write(2'd2, 32'd0);
        bus_write(2'd0, 32'h7);
        e0 = acc_edge;
        bus_read(2'd0, r); check("noper_ctrl", r, 32'h3);
        wait_irq(e0, d);
        check("noper_delay", d, TPT);
        bus_read(2'd3, r); check("noper_status", r, 32'h2);
`endif

        // Randomized one-shot runs against the closed-form timing rule
        for (int it = 0; it < 8; it++) begin
            int c0, cmp, ie, delta, t;
            cmp = int'($urandom_range(7, 0));
            c0  = int'($urandom_range(cmp, 0));
            ie  = int'($urandom_range(1, 0));
            bus_write(2'd0, 32'h8);
            bus_write(2'd1, c0);
            bus_write(2'd2, cmp);
            bus_write(2'd0, 32'h1 | (ie << 1));
            e0 = acc_edge;
            delta = (cmp - c0 + 1) * TPT;
            if (delta >= 5) begin
                t = int'($urandom_range(delta - 3, 2));
                wait_until(e0 + t - 1);
                bus_read(2'd1, r);
                check("rnd_count", r, c0 + (t - 1) / TPT);
            end
            wait_until(e0 + delta - 1);
            check("rnd_irq_before", {31'd0, irq}, 32'd0);
            wait_until(e0 + delta);
            check("rnd_irq_at", {31'd0, irq}, ie);
            bus_read(2'd0, r);
            check("rnd_ctrl", r, 32'h9 | (ie << 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
